pipe_hazard_ctrl: RTL and testbench

- Parametrised hazard controller for the pipelined MIPS core; sits beside the D-stage decoder.
- Tracks in-flight register writes in a shadow pipeline of {valid, write address, Tnew}, one entry per post-decode stage.
- Compares the D-stage instruction's Tuse values against that shadow pipeline and produces the stall and the D-stage forward-source selects.
- Optionally tracks a multi-cycle mult/div unit and stalls HI/LO consumers until it is free.

---
 rtl/pipe_hazard_ctrl.sv | 137 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// D-stage hazard controller: shadow write pipeline, Tuse/Tnew stall and forward-source select.
// Define MDU_HAZARD_EN to add the multi-cycle mult/div busy tracking.
module pipe_hazard_ctrl #(
  parameter int STAGES  = 3,
  parameter int REG_AW  = 5,
  parameter int T_W     = 2,
  parameter int MUL_CYC = 5,
  parameter int DIV_CYC = 10,
  localparam int FW     = $clog2(STAGES + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [REG_AW-1:0] d_rs,
  input  logic [REG_AW-1:0] d_rt,
  input  logic [T_W-1:0]    d_tuse_rs,
  input  logic [T_W-1:0]    d_tuse_rt,
  input  logic [REG_AW-1:0] d_waddr,
  input  logic              d_wen,
  input  logic [T_W-1:0]    d_tnew,
  input  logic              d_md_start,
  input  logic              d_md_is_div,
  input  logic              d_md_use,
  output logic              stall,
  output logic [FW-1:0]     d_fwd_rs,
  output logic [FW-1:0]     d_fwd_rt,
  output logic              md_busy
);

  logic              v_q     [1:STAGES];
  logic              v_d     [1:STAGES];
  logic [REG_AW-1:0] waddr_q [1:STAGES];
  logic [REG_AW-1:0] waddr_d [1:STAGES];
  logic [T_W-1:0]    tnew_q  [1:STAGES];
  logic [T_W-1:0]    tnew_d  [1:STAGES];

  logic [STAGES:1]   match_rs;
  logic [STAGES:1]   match_rt;
  logic [STAGES:1]   haz_rs;
  logic [STAGES:1]   haz_rt;
  logic              stall_rs;
  logic              stall_rt;
  logic              md_stall;

  genvar gi;
  generate
    for (gi = 1; gi <= STAGES; gi++) begin : g_stage
      if (gi == 1) begin : g_head
        // A stalled D instruction must not enter E: load a bubble instead.
        assign v_d[gi]     = d_wen & ~stall;
        assign waddr_d[gi] = d_waddr;
        assign tnew_d[gi]  = d_tnew;
      end else begin : g_tail
        assign v_d[gi]     = v_q[gi-1];
        assign waddr_d[gi] = waddr_q[gi-1];
        assign tnew_d[gi]  = (tnew_q[gi-1] == '0) ? '0 : tnew_q[gi-1] - T_W'(1);
      end

      assign match_rs[gi] = v_q[gi] && (waddr_q[gi] == d_rs) && (d_rs != '0);
      assign match_rt[gi] = v_q[gi] && (waddr_q[gi] == d_rt) && (d_rt != '0);
      assign haz_rs[gi]   = match_rs[gi] && (tnew_q[gi] > d_tuse_rs);
      assign haz_rt[gi]   = match_rt[gi] && (tnew_q[gi] > d_tuse_rt);
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 1; k <= STAGES; k++) begin
        v_q[k]     <= 1'b0;
        waddr_q[k] <= '0;
        tnew_q[k]  <= '0;
      end
    end else begin
      for (int k = 1; k <= STAGES; k++) begin
        v_q[k]     <= v_d[k];
        waddr_q[k] <= waddr_d[k];
        tnew_q[k]  <= tnew_d[k];
      end
    end
  end

  // Scan oldest to youngest so the youngest matching writer wins.
  always_comb begin
    d_fwd_rs = '0;
    d_fwd_rt = '0;
    for (int k = STAGES; k >= 1; k--) begin
      if (match_rs[k]) begin
        d_fwd_rs = (tnew_q[k] == '0) ? FW'(k) : '0;
      end
      if (match_rt[k]) begin
        d_fwd_rt = (tnew_q[k] == '0) ? FW'(k) : '0;
      end
    end
  end

  assign stall_rs = |haz_rs;
  assign stall_rt = |haz_rt;
  assign stall    = stall_rs | stall_rt | md_stall;

`ifdef MDU_HAZARD_EN
  localparam int MD_MAX = (MUL_CYC > DIV_CYC) ? MUL_CYC : DIV_CYC;
  localparam int CW     = $clog2(MD_MAX + 1);

  logic [CW-1:0] md_cnt_q;
  logic [CW-1:0] md_cnt_d;
  logic          md_start_ok;

  assign md_busy     = (md_cnt_q != '0);
  assign md_stall    = (d_md_use | d_md_start) & md_busy;
  // A start seen while busy is held in D by md_stall, so it never reloads the counter.
  assign md_start_ok = d_md_start & ~stall;

  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_start_ok) begin
      md_cnt_d = d_md_is_div ? CW'(DIV_CYC) : CW'(MUL_CYC);
    end else if (md_busy) begin
      md_cnt_d = md_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      md_cnt_q <= '0;
    end else begin
      md_cnt_q <= md_cnt_d;
    end
  end
`else
  localparam int unused_md_cyc = MUL_CYC + DIV_CYC;
  logic unused_md_inputs;

  assign unused_md_inputs = d_md_start ^ d_md_is_div ^ d_md_use;
  assign md_busy          = 1'b0;
  assign md_stall         = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a per-cycle vector table plus hand-written MDU and reset sequences.
module tb_pipe_hazard_ctrl;

  localparam int NV = 55;
`ifdef MDU_HAZARD_EN
  localparam logic MDU_ON = 1'b1;
`else
  localparam logic MDU_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] d_rs, d_rt, d_waddr;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       d_wen, d_md_start, d_md_is_div, d_md_use;
  logic       stall;
  logic [1:0] d_fwd_rs, d_fwd_rt;
  logic       md_busy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .d_rs       (d_rs),
    .d_rt       (d_rt),
    .d_tuse_rs  (d_tuse_rs),
    .d_tuse_rt  (d_tuse_rt),
    .d_waddr    (d_waddr),
    .d_wen      (d_wen),
    .d_tnew     (d_tnew),
    .d_md_start (d_md_start),
    .d_md_is_div(d_md_is_div),
    .d_md_use   (d_md_use),
    .stall      (stall),
    .d_fwd_rs   (d_fwd_rs),
    .d_fwd_rt   (d_fwd_rt),
    .md_busy    (md_busy)
  );

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [1:0] tur;
    logic [1:0] tut;
    logic [4:0] wa;
    logic       we;
    logic [1:0] tn;
    logic       es;
    logic [1:0] efr;
    logic [1:0] eft;
  } vec_t;

  vec_t tbl [NV];

  function automatic vec_t mk(input int rs, input int rt, input int tur, input int tut,
                              input int wa, input int we, input int tn,
                              input int es, input int efr, input int eft);
    vec_t v;
    v.rs  = 5'(rs);
    v.rt  = 5'(rt);
    v.tur = 2'(tur);
    v.tut = 2'(tut);
    v.wa  = 5'(wa);
    v.we  = 1'(we);
    v.tn  = 2'(tn);
    v.es  = 1'(es);
    v.efr = 2'(efr);
    v.eft = 2'(eft);
    return v;
  endfunction

  task automatic chk(input string tag, input string what, input int idx,
                     input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s.%s[%0d]: got %0d, expected %0d", tag, what, idx, act, expv);
    end
  endtask

  task automatic drive(input vec_t v, input logic ms, input logic mdiv, input logic mu);
    d_rs        = v.rs;
    d_rt        = v.rt;
    d_tuse_rs   = v.tur;
    d_tuse_rt   = v.tut;
    d_waddr     = v.wa;
    d_wen       = v.we;
    d_tnew      = v.tn;
    d_md_start  = ms;
    d_md_is_div = mdiv;
    d_md_use    = mu;
  endtask

  task automatic check_outs(input string tag, input int idx, input vec_t v, input logic eb);
    chk(tag, "stall",   idx, 32'(stall),    32'(v.es));
    chk(tag, "fwd_rs",  idx, 32'(d_fwd_rs), 32'(v.efr));
    chk(tag, "fwd_rt",  idx, 32'(d_fwd_rt), 32'(v.eft));
    chk(tag, "md_busy", idx, 32'(md_busy),  32'(eb));
    $display("%s[%0d] rs=%0d rt=%0d stall=%0b fwd_rs=%0d fwd_rt=%0d md_busy=%0b",
             tag, idx, d_rs, d_rt, stall, d_fwd_rs, d_fwd_rt, md_busy);
  endtask

  // One D-stage cycle: drive after the rising edge, check on the falling edge.
  task automatic cyc(input string tag, input int idx, input vec_t v,
                     input logic ms, input logic mdiv, input logic mu, input logic eb);
    drive(v, ms, mdiv, mu);
    @(negedge clk);
    check_outs(tag, idx, v, eb);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t nop_v;
    vec_t zero_v;
    nop_v  = mk(0, 0, 3, 3, 0, 0, 0, 0, 0, 0);
    zero_v = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < NV; i++) tbl[i] = nop_v;
    // lw $1 then add on $1 (tuse 1)
    tbl[0]  = mk(0, 0, 3, 3, 1, 1, 2, 0, 0, 0);
    tbl[1]  = mk(1, 0, 1, 1, 5, 1, 1, 1, 0, 0);
    tbl[2]  = mk(1, 0, 1, 1, 5, 1, 1, 0, 0, 0);
    // lw $1 then beq on $1 (tuse 0)
    tbl[6]  = mk(0, 0, 3, 3, 1, 1, 2, 0, 0, 0);
    tbl[7]  = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    tbl[8]  = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    tbl[9]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 3, 0);
    // add $2 then beq on $2
    tbl[13] = mk(0, 0, 3, 3, 2, 1, 1, 0, 0, 0);
    tbl[14] = mk(2, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    tbl[15] = mk(2, 0, 0, 0, 0, 0, 0, 0, 2, 0);
    // sub $2, addu $2, beq $2: youngest writer selected
    tbl[19] = mk(0, 0, 3, 3, 2, 1, 1, 0, 0, 0);
    tbl[20] = mk(0, 0, 3, 3, 2, 1, 1, 0, 0, 0);
    tbl[21] = mk(2, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    tbl[22] = mk(2, 0, 0, 0, 0, 0, 0, 0, 2, 0);
    // writer to $0 never matches
    tbl[26] = mk(0, 0, 3, 3, 0, 1, 2, 0, 0, 0);
    tbl[27] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[28] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // rs and rt hazards on different stages
    tbl[32] = mk(0, 0, 3, 3, 3, 1, 1, 0, 0, 0);
    tbl[33] = mk(0, 0, 3, 3, 4, 1, 2, 0, 0, 0);
    tbl[34] = mk(3, 4, 0, 0, 6, 1, 1, 1, 2, 0);
    tbl[35] = mk(3, 4, 0, 0, 6, 1, 1, 1, 3, 0);
    tbl[36] = mk(3, 4, 0, 0, 6, 1, 1, 0, 0, 3);
    // tnew=3 against unused (3) and tuse 1 on rt
    tbl[40] = mk(0, 0, 3, 3, 7, 1, 3, 0, 0, 0);
    tbl[41] = mk(0, 7, 3, 3, 0, 0, 0, 0, 0, 0);
    tbl[42] = mk(0, 7, 3, 1, 0, 0, 0, 1, 0, 0);
    tbl[43] = mk(0, 7, 3, 1, 0, 0, 0, 0, 0, 0);
    tbl[44] = mk(0, 7, 3, 1, 0, 0, 0, 0, 0, 0);
    // tnew=0 stays 0 through every stage: forward from 1, 2, 3
    tbl[45] = mk(0, 0, 3, 3, 8, 1, 0, 0, 0, 0);
    tbl[46] = mk(8, 0, 0, 3, 0, 0, 0, 0, 1, 0);
    tbl[47] = mk(8, 0, 0, 3, 0, 0, 0, 0, 2, 0);
    tbl[48] = mk(8, 0, 0, 3, 0, 0, 0, 0, 3, 0);
    // stalled writer must enter E as a bubble
    tbl[49] = mk(0, 0, 3, 3, 1, 1, 2, 0, 0, 0);
    tbl[50] = mk(1, 0, 0, 3, 9, 1, 2, 1, 0, 0);
    tbl[51] = mk(9, 0, 0, 3, 0, 0, 0, 0, 0, 0);

    // Reset state, with hazard-looking D inputs applied
    reset_n = 1'b0;
    drive(zero_v, 1'b1, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outs("reset", 0, zero_v, 1'b0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) cyc("vec", i, tbl[i], 1'b0, 1'b0, 1'b0, 1'b0);

    // mult then mfhi: 5 stall cycles, free on the 6th
    cyc("mult", 0, nop_v, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      cyc("mfhi", i, mk(0, 0, 3, 3, 0, 0, 0, int'(MDU_ON), 0, 0), 1'b0, 1'b0, 1'b1, MDU_ON);
    cyc("mfhi", 5, nop_v, 1'b0, 1'b0, 1'b1, 1'b0);

    // div then mult: mult held 10 cycles, then loads MUL_CYC
    cyc("div", 0, nop_v, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      cyc("mult_wait", i, mk(0, 0, 3, 3, 0, 0, 0, int'(MDU_ON), 0, 0), 1'b1, 1'b0, 1'b0, MDU_ON);
    cyc("mult_wait", 10, nop_v, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc("mult_run", i, nop_v, 1'b0, 1'b0, 1'b0, MDU_ON);
    cyc("mult_run", 5, nop_v, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset in the second cycle of a lw/beq stall, with a div in flight
    cyc("rst_lw", 0, mk(0, 0, 3, 3, 1, 1, 2, 0, 0, 0), 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("rst_beq", 0, mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0), 1'b0, 1'b0, 1'b0, MDU_ON);
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0, 1'b0);
    #2;
    chk("rst_pre", "stall", 0, 32'(stall), 32'd1);
    reset_n = 1'b0;
    #1;
    check_outs("rst_async", 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    @(posedge clk);
    #1;
    check_outs("rst_async", 1, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Fresh lw/beq after release
    cyc("post_lw", 0, mk(0, 0, 3, 3, 1, 1, 2, 0, 0, 0), 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("post_beq", 0, mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0), 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("post_beq", 1, mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0), 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("post_beq", 2, mk(1, 0, 0, 0, 0, 0, 0, 0, 3, 0), 1'b0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
